// File: rtl/lcm_gcd_pkg.sv
// Shared types and helpers for the GCD/LCM unit: FSM state encoding, mode
// encoding and a constant-foldable ceil(log2) for sizing counters.
package lcm_gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STEIN,
        DIV,
        MUL,
        DONE
    } state_t;

    localparam logic MODE_GCD = 1'b0;
    localparam logic MODE_LCM = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcm_gcd_unit_div.sv
// Restoring unsigned divider: loads on start, retires one quotient bit per
// cycle and raises done once all WIDTH bits are in; quotient then holds.
module seq_divider
    import lcm_gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CW = clog2(WIDTH + 1);

    logic             run_q, run_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   trial;

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        // A clear top bit means the shifted remainder covered the divisor.
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (start) begin
            run_d = 1'b1;
            cnt_d = CW'(WIDTH);
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
    end

    assign done     = run_q && (cnt_q == '0);
    assign quotient = quo_q;

endmodule

// File: rtl/lcm_gcd_unit.sv
// Iterative GCD/LCM behind a call/return handshake: binary Stein GCD, then for
// LCM a sequential divide b/g and a single full-width multiply a*(b/g).
module lcm_gcd_unit
    import lcm_gcd_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SAT_ON_OVF = 1'b0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             stall,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] returndata,
    output logic             overflow
);
    localparam int KW = clog2(WIDTH);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               ovf_q, ovf_d;

    logic               ops_zero;
    logic               stein_end;
    logic [WIDTH-1:0]   g_w;
    logic               div_start;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo;
    logic [2*WIDTH-1:0] product;

    function automatic logic [WIDTH-1:0] sat_result(input logic [2*WIDTH-1:0] p);
        if (SAT_ON_OVF && (|p[2*WIDTH-1:WIDTH])) return '1;
        return p[WIDTH-1:0];
    endfunction

    assign ops_zero  = (a == '0) || (b == '0);
    assign stein_end = (x_q == y_q);
    assign g_w       = x_q << k_q;
    assign div_start = (state_q == STEIN) && stein_end && (mode_q == MODE_LCM);
    assign product   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, div_quo};

    // b is an exact multiple of g, so the quotient needs no remainder check.
    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clock    (clock),
        .resetn   (resetn),
        .start    (div_start),
        .dividend (b_q),
        .divisor  (g_w),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        mode_q <= mode_d;
        a_q    <= a_d;
        b_q    <= b_d;
        x_q    <= x_d;
        y_q    <= y_d;
        k_q    <= k_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ops_zero ? DONE : STEIN;
            STEIN:   if (stein_end) state_d = (mode_q == MODE_LCM) ? DIV : DONE;
            DIV:     if (div_done) state_d = MUL;
            MUL:     state_d = DONE;
            DONE:    if (!stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        a_d    = a_q;
        b_d    = b_q;
        x_d    = x_q;
        y_d    = y_q;
        k_d    = k_q;
        res_d  = res_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    a_d    = a;
                    b_d    = b;
                    x_d    = a;
                    y_d    = b;
                    k_d    = '0;
                    if (ops_zero) begin
                        // With one operand zero, a|b is the other one (or zero).
                        res_d = (mode == MODE_LCM) ? '0 : (a | b);
                        ovf_d = 1'b0;
                    end
                end
            end
            STEIN: begin
                if (stein_end) begin
                    if (mode_q == MODE_GCD) begin
                        res_d = g_w;
                        ovf_d = 1'b0;
                    end
                end else if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1;
                    y_d = y_q >> 1;
                    k_d = k_q + 1'b1;
                end else if (!x_q[0]) begin
                    x_d = x_q >> 1;
                end else if (!y_q[0]) begin
                    y_d = y_q >> 1;
                end else if (x_q > y_q) begin
                    x_d = (x_q - y_q) >> 1;
                end else begin
                    y_d = (y_q - x_q) >> 1;
                end
            end
            MUL: begin
                res_d = sat_result(product);
                ovf_d = |product[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        returndata = res_q;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_lcm_gcd_unit.sv
// Bench for lcm_gcd_unit: two WIDTH=32 instances (wrap and saturate) share
// stimulus, plus a WIDTH=8 instance swept against a Euclid reference model.
module tb_lcm_gcd_unit;
    import lcm_gcd_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn;
    logic        start32, stall32, mode32;
    logic [31:0] a32, b32;
    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic [31:0] res0, res1;
    logic        start8, stall8, mode8;
    logic [7:0]  a8, b8, res8;
    logic        busy8, done8, ovf8;

    lcm_gcd_unit #(.WIDTH(32), .SAT_ON_OVF(1'b0)) dut_wrap (
        .clock(clock), .resetn(resetn), .start(start32), .busy(busy0), .done(done0),
        .stall(stall32), .mode(mode32), .a(a32), .b(b32), .returndata(res0), .overflow(ovf0));
    lcm_gcd_unit #(.WIDTH(32), .SAT_ON_OVF(1'b1)) dut_sat (
        .clock(clock), .resetn(resetn), .start(start32), .busy(busy1), .done(done1),
        .stall(stall32), .mode(mode32), .a(a32), .b(b32), .returndata(res1), .overflow(ovf1));
    lcm_gcd_unit #(.WIDTH(8), .SAT_ON_OVF(1'b1)) dut8 (
        .clock(clock), .resetn(resetn), .start(start8), .busy(busy8), .done(done8),
        .stall(stall8), .mode(mode8), .a(a8), .b(b8), .returndata(res8), .overflow(ovf8));

    typedef struct {
        logic [31:0] res_wrap;
        logic [31:0] res_sat;
        logic        ovf;
    } exp32_t;

    typedef struct {
        logic [7:0] res;
        logic       ovf;
    } exp8_t;

    typedef struct {
        logic        mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res_wrap;
        logic [31:0] res_sat;
        logic        ovf;
        int          max_lat;
    } vec_t;

    exp32_t sb32[$];
    exp8_t  sb8[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_lat(input string name, input int lat, input int max_lat);
        n_tests++;
        if (lat > max_lat) begin
            n_fail++;
            $display("FAIL %s: latency %0d cycles, want <= %0d", name, lat, max_lat);
        end
    endtask

    function automatic logic [63:0] ref_gcd(input logic [63:0] x_in, input logic [63:0] y_in);
        logic [63:0] x, y, t;
        x = x_in;
        y = y_in;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic exp32_t model32(input logic m, input logic [31:0] x, input logic [31:0] y);
        exp32_t      e;
        logic [63:0] g, l;
        g = ref_gcd(64'(x), 64'(y));
        if (m == MODE_GCD) begin
            e = '{g[31:0], g[31:0], 1'b0};
        end else if (x == 0 || y == 0) begin
            e = '{32'd0, 32'd0, 1'b0};
        end else begin
            l = (64'(x) / g) * 64'(y);
            e.ovf      = (l[63:32] != 0);
            e.res_wrap = l[31:0];
            e.res_sat  = e.ovf ? 32'hFFFF_FFFF : l[31:0];
        end
        return e;
    endfunction

    function automatic exp8_t model8(input logic m, input logic [7:0] x, input logic [7:0] y);
        exp8_t       e;
        logic [63:0] g, l;
        g = ref_gcd(64'(x), 64'(y));
        if (m == MODE_GCD) begin
            e = '{g[7:0], 1'b0};
        end else if (x == 0 || y == 0) begin
            e = '{8'd0, 1'b0};
        end else begin
            l = (64'(x) / g) * 64'(y);
            e.ovf = (l > 64'd255);
            e.res = e.ovf ? 8'hFF : l[7:0];
        end
        return e;
    endfunction

    always @(negedge clock) begin : mon32
        exp32_t e;
        if (resetn && done0 && !stall32) begin
            if (sb32.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done32_unexpected: got done=1, want no result pending");
            end else begin
                e = sb32.pop_front();
                check("res_wrap", 64'(res0), 64'(e.res_wrap));
                check("res_sat", 64'(res1), 64'(e.res_sat));
                check("ovf_wrap", 64'(ovf0), 64'(e.ovf));
                check("ovf_sat", 64'(ovf1), 64'(e.ovf));
                check("done_sat", 64'(done1), 64'd1);
            end
        end
    end

    always @(negedge clock) begin : mon8
        exp8_t e;
        if (resetn && done8 && !stall8) begin
            if (sb8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done8_unexpected: got done=1, want no result pending");
            end else begin
                e = sb8.pop_front();
                check("res8", 64'(res8), 64'(e.res));
                check("ovf8", 64'(ovf8), 64'(e.ovf));
            end
        end
    end

    task automatic accept32(input logic m, input logic [31:0] x, input logic [31:0] y, input exp32_t e);
        int guard;
        guard = 0;
        @(posedge clock); #1;
        while (busy0 && guard < 300) begin
            @(posedge clock); #1;
            guard++;
        end
        check("idle_before_call", 64'(busy0), 64'd0);
        sb32.push_back(e);
        start32 = 1'b1;
        mode32  = m;
        a32     = x;
        b32     = y;
        @(posedge clock); #1;
        start32 = 1'b0;
        check("busy_after_accept", 64'(busy0), 64'd1);
    endtask

    task automatic wait_done32(output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!done0 && lat < 200);
    endtask

    task automatic drain32();
        int guard;
        guard = 0;
        while (done0 && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        check("done32_drop", 64'(done0), 64'd0);
    endtask

    task automatic call32(input logic m, input logic [31:0] x, input logic [31:0] y,
                          input exp32_t e, input int max_lat, input string name);
        int lat;
        accept32(m, x, y, e);
        wait_done32(lat);
        check_lat(name, lat, max_lat);
        drain32();
    endtask

    vec_t       vecs[17];
    logic [7:0] cx[6] = '{8'd0, 8'd255, 8'd255, 8'd1, 8'd128, 8'd0};
    logic [7:0] cy[6] = '{8'd0, 8'd254, 8'd255, 8'd255, 8'd64, 8'd9};

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        exp32_t      e;
        exp8_t       e8;
        int          lat;
        int          seen;
        logic        m;
        logic [31:0] x, y, c;
        logic [7:0]  x8, y8, c8;

        vecs[0]  = '{MODE_GCD, 32'd12, 32'd18, 32'd6, 32'd6, 1'b0, 65};
        vecs[1]  = '{MODE_LCM, 32'd12, 32'd18, 32'd36, 32'd36, 1'b0, 98};
        vecs[2]  = '{MODE_LCM, 32'd7, 32'd7, 32'd7, 32'd7, 1'b0, 98};
        vecs[3]  = '{MODE_LCM, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1};
        vecs[4]  = '{MODE_LCM, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h2, 32'hFFFF_FFFF, 1'b1, 98};
        vecs[5]  = '{MODE_GCD, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1};
        vecs[6]  = '{MODE_GCD, 32'd0, 32'd77, 32'd77, 32'd77, 1'b0, 1};
        vecs[7]  = '{MODE_GCD, 32'd91, 32'd0, 32'd91, 32'd91, 1'b0, 1};
        vecs[8]  = '{MODE_LCM, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1};
        vecs[9]  = '{MODE_GCD, 32'd48, 32'd180, 32'd12, 32'd12, 1'b0, 65};
        vecs[10] = '{MODE_GCD, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 65};
        vecs[11] = '{MODE_GCD, 32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 65};
        vecs[12] = '{MODE_LCM, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 98};
        vecs[13] = '{MODE_LCM, 32'h1_0000, 32'h3_0000, 32'h3_0000, 32'h3_0000, 1'b0, 98};
        vecs[14] = '{MODE_LCM, 32'h1_0000, 32'h1_0001, 32'h1_0000, 32'hFFFF_FFFF, 1'b1, 98};
        vecs[15] = '{MODE_LCM, 32'hC000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 98};
        vecs[16] = '{MODE_GCD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 65};

        resetn  = 1'b0;
        start32 = 1'b0; stall32 = 1'b0; mode32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; stall8  = 1'b0; mode8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_res", 64'(res0), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_res8", 64'(res8), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            e = '{vecs[i].res_wrap, vecs[i].res_sat, vecs[i].ovf};
            call32(vecs[i].mode, vecs[i].a, vecs[i].b, e, vecs[i].max_lat, $sformatf("lat_vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            c = 32'($urandom_range(1, 1000));
            x = c * 32'($urandom_range(0, 4000000));
            y = c * 32'($urandom_range(0, 4000000));
            m = 1'($urandom_range(0, 1));
            call32(m, x, y, model32(m, x, y), m ? 98 : 65, $sformatf("lat_rand%0d", i));
        end

        // Result held under stall; start pulses during DONE must be ignored.
        stall32 = 1'b1;
        e = '{32'd12, 32'd12, 1'b0};
        accept32(MODE_GCD, 32'd48, 32'd180, e);
        wait_done32(lat);
        check_lat("lat_stall", lat, 65);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            start32 = 1'(i % 2);
            mode32  = MODE_LCM;
            a32     = 32'd5;
            b32     = 32'd7;
            @(negedge clock);
            check("stall_done", 64'(done0), 64'd1);
            check("stall_res", 64'(res0), 64'd12);
            check("stall_busy", 64'(busy0), 64'd1);
        end
        @(posedge clock); #1;
        stall32 = 1'b0;
        start32 = 1'b1;
        @(posedge clock); #1;
        start32 = 1'b0;
        check("consume_done", 64'(done0), 64'd0);
        check("consume_busy", 64'(busy0), 64'd0);
        @(negedge clock);
        check("consume_start_ignored", 64'(busy0), 64'd0);
        call32(MODE_GCD, 32'd9, 32'd3, '{32'd3, 32'd3, 1'b0}, 65, "lat_after_stall");

        // Reset in the middle of the Stein loop aborts the call silently.
        accept32(MODE_GCD, 32'd1000, 32'd750, '{32'd250, 32'd250, 1'b0});
        @(posedge clock); #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        check("abort_busy", 64'(busy0), 64'd0);
        check("abort_done", 64'(done0), 64'd0);
        check("abort_res", 64'(res0), 64'd0);
        check("abort_ovf", 64'(ovf0), 64'd0);
        check("abort_busy_sat", 64'(busy1), 64'd0);
        resetn = 1'b1;
        sb32.delete();
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done0) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        call32(MODE_GCD, 32'd1000, 32'd750, '{32'd250, 32'd250, 1'b0}, 65, "lat_after_reset");

        for (int i = 0; i < 312; i++) begin
            if (i < 12) begin
                x8 = cx[i / 2];
                y8 = cy[i / 2];
                m  = 1'(i % 2);
            end else if (i % 2 == 0) begin
                c8 = 8'($urandom_range(1, 16));
                x8 = 8'(c8 * 8'($urandom_range(0, 15)));
                y8 = 8'(c8 * 8'($urandom_range(0, 15)));
                m  = 1'($urandom_range(0, 1));
            end else begin
                x8 = 8'($urandom_range(0, 255));
                y8 = 8'($urandom_range(0, 255));
                m  = 1'($urandom_range(0, 1));
            end
            e8 = model8(m, x8, y8);
            sb8.push_back(e8);
            @(posedge clock); #1;
            start8 = 1'b1;
            mode8  = m;
            a8     = x8;
            b8     = y8;
            @(posedge clock); #1;
            start8 = 1'b0;
            lat = 0;
            do begin
                @(negedge clock);
                lat++;
            end while (!done8 && lat < 40);
            check_lat($sformatf("lat8_%0d", i), lat, m ? 26 : 17);
            @(posedge clock); #1;
        end
        check("sb8_empty", 64'(sb8.size()), 64'd0);
        check("sb32_empty", 64'(sb32.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
